// File: rtl/prog_loader_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_arbiter
// Purpose  : Owns the single write/read port of the computador instruction/
//            data memory. After reset the CPU is held stalled while host
//            words are streamed into consecutive addresses from 0. The CPU is
//            then released, and its memory accesses are forwarded to the port.
//            A reload request pauses the CPU and restarts loading.
// Ports    : clock, resetn        - clock (rising edge), async active-low reset
//            ld_valid/ld_data/ld_last/ld_ready - host program stream
//            ld_start             - reload request (honoured in RUN only)
//            cpu_req/cpu_we/cpu_addr/cpu_wdata - CPU access request
//            cpu_gnt              - one-cycle grant pulse
//            cpu_run              - CPU enable (stalled while 0)
//            mem_addr/mem_wdata/mem_wr - registered memory port
//            load_count           - words written by current/most recent load
//            state                - LOAD=0, BOOT=1, RUN=2, PAUSE=3
//            ld_csum              - running sum of loaded words (optional)
// Config   : define PROG_LOADER_CHECKSUM_EN to add the ld_csum output.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              ld_start,
  output logic              ld_ready,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] load_count,
`ifdef PROG_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] ld_csum,
`endif
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  // Highest address; accepting a word here fills the memory completely.
  localparam logic [ADDR_W-1:0] c_last_addr = '1;

  state_t              r_state,      w_state_nxt;
  logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata;
  logic                r_mem_wr,     w_mem_wr;
  logic                r_cpu_gnt,    w_cpu_gnt;
  logic [ADDR_W-1:0]   r_load_count, w_load_count;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   r_csum,       w_csum;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_LOAD;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wr     <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_load_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_mem_wr     <= w_mem_wr;
      r_cpu_gnt    <= w_cpu_gnt;
      r_load_count <= w_load_count;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum       <= w_csum;
`endif
    end
  end

  always_comb begin
    // Address/data hold their last value; strobes fall back to 0.
    w_state_nxt  = r_state;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_mem_wr     = 1'b0;
    w_cpu_gnt    = 1'b0;
    w_load_count = r_load_count;
`ifdef PROG_LOADER_CHECKSUM_EN
    w_csum       = r_csum;
`endif
    case (r_state)
      ST_LOAD: begin
        // ld_ready is 1 throughout LOAD, so ld_valid alone marks acceptance.
        if (ld_valid) begin
          w_mem_addr   = r_load_count;
          w_mem_wdata  = ld_data;
          w_mem_wr     = 1'b1;
          w_load_count = r_load_count + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          w_csum       = r_csum + ld_data;
`endif
          if (ld_last || (r_load_count == c_last_addr)) begin
            w_state_nxt = ST_BOOT;
          end
        end
      end
      ST_BOOT: begin
        // Single cycle in which the final load write retires.
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A CPU access in the same cycle as a reload request is still served.
        if (cpu_req) begin
          w_mem_addr  = cpu_addr;
          w_mem_wdata = cpu_wdata;
          w_mem_wr    = cpu_we;
          w_cpu_gnt   = 1'b1;
        end
        if (ld_start) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        w_load_count = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_csum       = '0;
`endif
        w_state_nxt  = ST_LOAD;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  assign ld_ready   = (r_state == ST_LOAD);
  assign cpu_run    = (r_state == ST_RUN);
  assign state      = r_state;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wr     = r_mem_wr;
  assign cpu_gnt    = r_cpu_gnt;
  assign load_count = r_load_count;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign ld_csum    = r_csum;
`endif

endmodule
`default_nettype wire

// File: doc/prog_loader_arbiter.md
# prog_loader_arbiter

Owns the single memory write/read port of the `computador` instruction/data memory and shares it between the external program loader (host side) and the processor. After reset, the block holds the CPU stalled, streams host words into consecutive addresses from 0, then releases the CPU. While the CPU runs, the block arbitrates its memory accesses. A reload request pauses the CPU cleanly and restarts loading.

## Interface
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 16: memory word width.

- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ld_valid` in 1: host word present on `ld_data`.
- `ld_data` in DATA_W: program word.
- `ld_last` in 1: qualifies the final word of a program.
- `ld_start` in 1: reload request, honoured only in RUN.
- `ld_ready` out 1: block accepts a host word this cycle.
- `cpu_req` in 1: CPU memory access request.
- `cpu_we` in 1: CPU write enable.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_gnt` out 1: one-cycle grant pulse for a CPU access.
- `cpu_run` out 1: CPU enable; the CPU is stalled while this is 0.
- `mem_addr` out ADDR_W: memory address (registered).
- `mem_wdata` out DATA_W: memory write data (registered).
- `mem_wr` out 1: memory write strobe (registered).
- `load_count` out ADDR_W: number of words written by the current or most recent load.
- `state` out 2: LOAD=0, BOOT=1, RUN=2, PAUSE=3.

## Operation
- Reset values:
  - state=LOAD
  - ld_ready=1
  - load_count=0
  - cpu_run=0
  - cpu_gnt=0
  - mem_addr=0
  - mem_wdata=0
  - mem_wr=0
- LOAD:
  - `ld_ready`=1.
  - A transfer is accepted when `ld_valid`=1 and `ld_ready`=1. On acceptance:
    - mem_addr ← load_count
    - mem_wdata ← ld_data
    - mem_wr ← 1
    - load_count ← load_count+1
  - Accepting a word with `ld_last`=1 → BOOT. `ld_ready` drops in the following cycle.
  - Accepting at address 2^ADDR_W−1 is an implicit last word: → BOOT. load_count wraps to 0, which means a full memory.
  - `cpu_req` is ignored in LOAD and `cpu_gnt` stays 0.
- BOOT:
  - Lasts exactly one cycle and is used to let the final write retire. mem_wr=0.
  - → RUN. cpu_run=1 from the first RUN cycle.
- RUN:
  - `ld_ready`=0 and `ld_valid` is ignored.
  - On each `cpu_req`=1, the next cycle shows:
    - mem_addr=cpu_addr
    - mem_wdata=cpu_wdata
    - mem_wr=cpu_we
    - cpu_gnt=1
  - Back-to-back requests are granted every cycle.
  - `ld_start`=1 → PAUSE. If `cpu_req`=1 in the same cycle, that access is still granted (the CPU wins the tie). cpu_run drops in the next cycle.
- PAUSE:
  - Lasts one cycle. cpu_run=0, mem_wr=0, and no grants.
  - load_count ← 0 → LOAD.
- Registered outputs hold their values across cycles with no transfer, except mem_wr and cpu_gnt, which return to 0.
- If `resetn` is asserted mid-load or mid-run, all state is cleared immediately (asynchronously). A partially loaded program is not resumed.

## Timing
- Host word: accepted at edge n; mem_wr=1 in cycle n+1. Throughput is 1 word/cycle.
- Last word accepted at edge n:
  - BOOT during n+1, with the last mem_wr pulse.
  - RUN and cpu_run=1 at n+2.
  - The first CPU grant is possible at n+3.
- CPU request sampled at edge n: cpu_gnt and the mem_* outputs are valid in cycle n+1. Latency is 1 cycle.
- `ld_start` sampled at edge n in RUN:
  - PAUSE in n+1 (cpu_run=0).
  - LOAD in n+2 (ld_ready=1).
- The `ld_*` and `cpu_*` inputs must be synchronous to `clock`.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - Adds output `ld_csum` (DATA_W), reset 0.
  - `ld_csum` is cleared on entry to LOAD.
  - Each accepted word adds `ld_data` modulo 2^DATA_W.
  - The value is stable from BOOT onward, so the host can compare it against its own sum before trusting the program.
- Macro absent: no `ld_csum` port and no adder logic. All other behaviour is identical.

## Test plan
- Reset then load 11 words 0xA000, 0xA401, … with `ld_last` on word 11:
  - mem_wr pulses at addresses 0..10 with matching data.
  - load_count=11.
  - state goes LOAD→BOOT→RUN.
  - cpu_run=1 exactly 2 cycles after the last accept.
- `cpu_req` held during LOAD: no cpu_gnt and no mem_wr from the CPU. Once in RUN, a request with addr=0x0005 and we=1, wdata=0x1234 gives mem_addr=5, mem_wdata=0x1234, mem_wr=1, cpu_gnt=1 one cycle later.
- Three consecutive CPU reads (we=0) at addresses 1, 2, 3: three consecutive cpu_gnt pulses, mem_wr stays 0.
- In RUN, `ld_start`=1 together with `cpu_req`:
  - That access is granted.
  - PAUSE for 1 cycle with cpu_run=0.
  - Then LOAD with load_count=0.
  - A new word goes to address 0.
- `resetn` pulsed low after 4 words: all outputs are at reset values immediately, before the next clock edge. A subsequent load restarts at address 0.
- With `PROG_LOADER_CHECKSUM_EN`, loading 0xFFFF, 0x0002, 0x0010: ld_csum=0x0011.
